// File: rtl/pulpino_board_pkg.sv
// Shared definitions for the PULPino board-level reset sequencer.
// Holds the sequencer state encoding, which is also driven onto the board
// LEDs, and the default timing constants used on the 50 MHz board clock.
package pulpino_board_pkg;

  // The encoding is visible on the LEDs, so the values are fixed.
  typedef enum logic [1:0] {
    ST_POR  = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } rst_state_e;

  // 10 ms of stable input at 50 MHz
  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  // SoC reset stretch; must cover at least 4 divided SoC clocks on the board
  localparam int POR_CYCLES_DEF      = 1024;
  // Gap between SoC reset release and the earliest fetch enable
  localparam int FETCH_DELAY_DEF     = 256;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulpino_rst_ctrl_if.sv
// Board-side signal bundle of the reset sequencer.
//   rst_btn_n    : raw reset push-button, active-low, asynchronous to clk
//   fetch_sw_n   : raw fetch-enable switch, active-low, asynchronous to clk
//   soc_rst_n    : conditioned SoC reset, active-low
//   fetch_enable : conditioned fetch enable, active-high
//   state_o      : sequencer state for the board LEDs
// master = board/pin side, slave = sequencer.
interface pulpino_rst_ctrl_if;

  logic       rst_btn_n;
  logic       fetch_sw_n;
  logic       soc_rst_n;
  logic       fetch_enable;
  logic [1:0] state_o;

  modport master (
    output rst_btn_n,
    output fetch_sw_n,
    input  soc_rst_n,
    input  fetch_enable,
    input  state_o
  );

  modport slave (
    input  rst_btn_n,
    input  fetch_sw_n,
    output soc_rst_n,
    output fetch_enable,
    output state_o
  );

endinterface

// File: rtl/pulpino_debounce.sv
// Two-flop synchronizer followed by a counting debouncer for one raw pin.
//   clk   : board clock
//   rst_n : asynchronous active-low reset
//   din   : raw pin, asynchronous to clk
//   dout  : debounced level; equals the value the stable register holds
//           after the coming clk edge, so downstream logic acts on the same
//           edge the new level is committed
// A level is accepted after DEBOUNCE_CYCLES consecutive differing
// synchronized samples; anything shorter is discarded.
module pulpino_debounce
  import pulpino_board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             commit;

  assign differ = (sync_p1 != stable);
  assign commit = differ && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      stable  <= 1'b1;
      cnt     <= '0;
    end else begin
      // synchronizer stage boundary: p0 -> p1
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      // debounce stage boundary: p1 -> stable
      if (!differ) begin
        cnt <= '0;
      end else if (commit) begin
        stable <= sync_p1;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Look-ahead of the stable register; once commit is true the new level
  // is certain to be taken on this edge, so it can be exposed immediately.
  assign dout = commit ? sync_p1 : stable;

endmodule

// File: rtl/pulpino_rst_ctrl.sv
// Board-level reset and start-up sequencer for PULPino on the ICBv1 board.
//   clk   : 50 MHz board clock, the only clock
//   rst_n : asynchronous active-low board power-good
//   bus   : slave side of pulpino_rst_ctrl_if (raw button and switch in,
//           conditioned soc_rst_n / fetch_enable and LED state out)
// Sequence: POR (hold SoC reset POR_CYCLES) -> WAIT (FETCH_DELAY cycles with
// SoC out of reset) -> RUN (fetch enable follows the switch). A debounced
// button press from any of these goes to HOLD; release restarts at POR.
module pulpino_rst_ctrl
  import pulpino_board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int POR_CYCLES      = POR_CYCLES_DEF,
  parameter int FETCH_DELAY     = FETCH_DELAY_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  pulpino_rst_ctrl_if.slave   bus
);

  // One counter is shared by POR and WAIT since they never overlap.
  localparam int               CNT_MAX    = max_int(POR_CYCLES, FETCH_DELAY);
  localparam int               CNT_W      = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] POR_LAST   = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(FETCH_DELAY - 1);

  logic             btn_db;
  logic             sw_db;
  logic             pressed;
  rst_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             soc_rst;
  logic             fetch_en;

  pulpino_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_db (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.rst_btn_n),
    .dout  (btn_db)
  );

  pulpino_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_db (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.fetch_sw_n),
    .dout  (sw_db)
  );

  assign pressed = ~btn_db;

  // Outputs are registered here; a press outranks counter completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_POR;
      cnt      <= '0;
      soc_rst  <= 1'b0;
      fetch_en <= 1'b0;
    end else begin
      case (state)
        ST_POR: begin
          fetch_en <= 1'b0;
          if (pressed) begin
            state   <= ST_HOLD;
            cnt     <= '0;
            soc_rst <= 1'b0;
          end else if (cnt == POR_LAST) begin
            state   <= ST_WAIT;
            cnt     <= '0;
            soc_rst <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_WAIT: begin
          fetch_en <= 1'b0;
          if (pressed) begin
            state   <= ST_HOLD;
            cnt     <= '0;
            soc_rst <= 1'b0;
          end else if (cnt == FETCH_LAST) begin
            state <= ST_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (pressed) begin
            state    <= ST_HOLD;
            cnt      <= '0;
            soc_rst  <= 1'b0;
            fetch_en <= 1'b0;
          end else begin
            // switch is free to toggle while running
            fetch_en <= ~sw_db;
          end
        end
        ST_HOLD: begin
          soc_rst  <= 1'b0;
          fetch_en <= 1'b0;
          cnt      <= '0;
          if (!pressed) begin
            state <= ST_POR;
          end
        end
        default: begin
          state    <= ST_POR;
          cnt      <= '0;
          soc_rst  <= 1'b0;
          fetch_en <= 1'b0;
        end
      endcase
    end
  end

  assign bus.soc_rst_n    = soc_rst;
  assign bus.fetch_enable = fetch_en;
  assign bus.state_o      = state;

endmodule

// File: doc/pulpino_rst_ctrl.md
# pulpino_rst_ctrl

Board-level reset and start-up sequencer that sits directly upstream of the PULPino board wrapper on the ICBv1 FPGA board. It conditions the raw reset push-button and fetch-enable switch, stretches a power-on reset, and releases the SoC reset and fetch enable in a fixed order. Its outputs drive the wrapper's `rst_n` and `fetch_enable_n` inputs through board glue.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive stable synchronized samples needed to accept a level change (10 ms at 50 MHz); must be ≥1.
- `POR_CYCLES`, default 1024: number of `clk` cycles the SoC reset is held after power-on or after button release; must be ≥40 on the board (4 divided SoC clocks) and ≥1 in simulation.
- `FETCH_DELAY`, default 256: number of `clk` cycles between SoC reset release and the earliest fetch enable; must be ≥1.
- `clk` input 1: board clock, 50 MHz; the only clock.
- `rst_n` input 1: asynchronous, active-low reset (board power-good).
- `rst_btn_n` input 1: raw reset push-button, active-low, asynchronous to `clk`.
- `fetch_sw_n` input 1: raw fetch-enable switch, active-low, asynchronous to `clk`.
- `soc_rst_n` output 1: conditioned SoC reset, active-low, registered.
- `fetch_enable` output 1: conditioned fetch enable, active-high, registered.
- `state_o` output 2: current FSM state, for the board LEDs.

## Operation
- Each raw input goes through a 2-FF synchronizer and then a debouncer. Synchronizer flops reset to 1.
- Debouncer: `stable` resets to 1 and `cnt` resets to 0.
  - If the synchronized sample equals `stable`, `cnt` is set to 0.
  - Otherwise `cnt` increments. When `cnt == DEBOUNCE_CYCLES-1` and the sample still differs, `stable` takes the sample and `cnt` is set to 0.
  - `cnt` width is `$clog2(DEBOUNCE_CYCLES+1)`.
- FSM states, encoded on `state_o`: POR=0, WAIT=1, RUN=2, HOLD=3.
  - POR: the cycle counter runs from 0. When it reaches `POR_CYCLES-1`, go to WAIT, clear the counter, and set `soc_rst_n` to 1.
  - WAIT: the counter runs from 0. When it reaches `FETCH_DELAY-1`, go to RUN.
  - RUN: on every edge, `fetch_enable` is set to the inverse of the debounced `fetch_sw_n`. The switch can be toggled freely while in RUN.
  - HOLD: `soc_rst_n` and `fetch_enable` are 0. Stay in HOLD while the debounced button is pressed. On release, go to POR with the counter at 0.
- A debounced button press (debounced `rst_btn_n` == 0) in POR, WAIT or RUN has priority over counter completion. On that same edge: state becomes HOLD, counter is cleared, `soc_rst_n` is set to 0, `fetch_enable` is set to 0.
- `fetch_enable` is 0 in every state other than RUN.
- If the switch is already on at power-up, `fetch_enable` rises on the first RUN edge.

## Timing
- Reset values: `soc_rst_n`=0, `fetch_enable`=0, `state_o`=0 (POR), counter=0, debouncer `stable`=1.
- Asserting `rst_n` mid-operation forces all of the above reset values immediately (asynchronously). Deassertion takes effect on the next `clk` edge.
- Raw pin change to debounced change: 2 + `DEBOUNCE_CYCLES` cycles. A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles causes no change.
- `soc_rst_n` rises on the `POR_CYCLES`-th rising edge after POR entry.
- `fetch_enable` rises `FETCH_DELAY`+1 edges after `soc_rst_n` rises (assuming the debounced switch is on).
- Reset-button path:
  - `soc_rst_n` and `fetch_enable` fall on the edge at which the debouncer output first reads pressed.
  - The edge after that, the FSM is in HOLD with both outputs low.
- A debounced button release in HOLD enters POR on the next edge. From there the full POR → WAIT → RUN sequence repeats.

## Structure
- Shared package `pulpino_board_pkg`: holds the state enum (POR/WAIT/RUN/HOLD with the encodings above) and the default constants for `DEBOUNCE_CYCLES`, `POR_CYCLES` and `FETCH_DELAY`.
- Sub-module `pulpino_debounce`: 2-FF synchronizer plus debouncer, parameter `DEBOUNCE_CYCLES`, ports `clk`, `rst_n`, `din`, `dout`. It is instantiated twice in `pulpino_rst_ctrl`.
- The FSM and the shared POR/WAIT counter live in the top module. The counter is sized for max(`POR_CYCLES`, `FETCH_DELAY`).

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `POR_CYCLES`=8, `FETCH_DELAY`=4, with the fetch switch on unless stated.
- Power-up: release `rst_n` -> `soc_rst_n`=1 after edge 8, `fetch_enable`=1 after edge 13; `state_o` steps 0→1→2.
- Glitch rejection: pulse `rst_btn_n` low for 3 synchronized cycles while in RUN -> no change on any output.
- Button press in RUN: hold `rst_btn_n` low for 20 cycles -> both outputs go low at raw+6 edges and `state_o`=3. After release, the debounced release leads to POR, then `soc_rst_n` rises 8 edges later.
- Switch off at power-up: `fetch_sw_n`=1 -> RUN is reached with `fetch_enable`=0. Driving the switch low gives `fetch_enable`=1 at raw+6 edges.
- Press during POR and at the WAIT→RUN boundary: HOLD is entered and `fetch_enable` never pulses.
- Asynchronous reset: assert `rst_n` in RUN -> `soc_rst_n`=0, `fetch_enable`=0, `state_o`=0 within the same cycle, with no clock edge needed.
